// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Brief    : Shared state codes and helpers for the parametrised router FSM.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    typedef logic [3:0] state_t;

    localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
    localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
    localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd2;
    localparam logic [3:0] LOAD_DATA          = 4'd3;
    localparam logic [3:0] FIFO_FULL_STATE    = 4'd4;
    localparam logic [3:0] LOAD_PARITY        = 4'd5;
    localparam logic [3:0] LOAD_AFTER_FULL    = 4'd6;
    localparam logic [3:0] CHECK_PARITY_ERROR = 4'd7;
    localparam logic [3:0] DROP_DATA          = 4'd8;
    localparam logic [3:0] DROP_PARITY        = 4'd9;

    function automatic int addr_w(input int num_ports);
        int w;
        w = $clog2(num_ports);
        return (w < 1) ? 1 : w;
    endfunction

    // Bit 'bitpos' of the one-hot encoding of 'idx'.
    function automatic logic onehot_bit(input logic [3:0] idx, input int unsigned bitpos);
        return ({28'd0, idx} == bitpos);
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : router_wait_timer
// Brief    : Cycle counter with clear/enable that flags the last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
module router_wait_timer #(
    parameter int TIMEOUT = 0,
    parameter int TMR_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TMR_W'(1);
        end
    end

    // A zero timeout means wait forever.
    assign o_expire = (TIMEOUT != 0) && (r_count == TMR_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/router_fsm_np.sv
`default_nettype none
// ============================================================================
// Module   : router_fsm_np
// Brief    : Control FSM steering one packet stream to one of NUM_PORTS FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module router_fsm_np
    import router_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = addr_w(NUM_PORTS),
    parameter int WAIT_TIMEOUT = 0,
    parameter int TMR_W        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 pkt_valid,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 pkt_drop
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_dest;
    logic              r_in_drop;
    logic              w_in_range;
    logic              w_empty_in;
    logic              w_empty_dest;
    logic              w_full_dest;
    logic              w_sr_dest;
    logic              w_expire;
    logic              w_sel_en;

    // Per-port selects only ever touch in-range bits; an unmatched address reads as 0.
    always_comb begin
        w_in_range   = 1'b0;
        w_empty_in   = 1'b0;
        w_empty_dest = 1'b0;
        w_full_dest  = 1'b0;
        w_sr_dest    = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (onehot_bit(4'(data_in), p)) begin
                w_in_range = 1'b1;
                w_empty_in = fifo_empty[p];
            end
            if (onehot_bit(4'(r_dest), p)) begin
                w_empty_dest = fifo_empty[p];
                w_full_dest  = fifo_full[p];
                w_sr_dest    = soft_reset[p];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!w_in_range)     w_next = DROP_DATA;
                    else if (w_empty_in) w_next = LOAD_FIRST_DATA;
                    else                 w_next = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: w_next = LOAD_DATA;
            WAIT_TILL_EMPTY: begin
                if (w_empty_dest)  w_next = LOAD_FIRST_DATA;
                else if (w_expire) w_next = DROP_DATA;
            end
            LOAD_DATA: begin
                if (w_full_dest)     w_next = FIFO_FULL_STATE;
                else if (!pkt_valid) w_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: if (!w_full_dest) w_next = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)        w_next = DECODE_ADDRESS;
                else if (low_pkt_valid) w_next = LOAD_PARITY;
                else                    w_next = LOAD_DATA;
            end
            LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: w_next = w_full_dest ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_DATA:          if (!pkt_valid) w_next = DROP_PARITY;
            DROP_PARITY:        w_next = DECODE_ADDRESS;
            default:            w_next = DECODE_ADDRESS;
        endcase
        // Drop states carry an out-of-range destination, so soft reset cannot apply there.
        if (w_sr_dest && (r_state != DECODE_ADDRESS) && (r_state <= CHECK_PARITY_ERROR)) begin
            w_next = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= DECODE_ADDRESS;
            r_dest    <= '0;
            r_in_drop <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_in_drop <= (r_state == DROP_DATA);
            if ((r_state == DECODE_ADDRESS) && pkt_valid) begin
                r_dest <= data_in;
            end
        end
    end

    router_wait_timer #(
        .TIMEOUT (WAIT_TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_wait_timer (
        .clk      (clock),
        .rst      (reset),
        .i_clear  (w_next != WAIT_TILL_EMPTY),
        .i_enable ((r_state == WAIT_TILL_EMPTY) && (w_next == WAIT_TILL_EMPTY)),
        .o_expire (w_expire)
    );

    always_comb begin
        detect_add    = (r_state == DECODE_ADDRESS);
        lfd_state     = (r_state == LOAD_FIRST_DATA);
        ld_state      = (r_state == LOAD_DATA);
        laf_state     = (r_state == LOAD_AFTER_FULL);
        full_state    = (r_state == FIFO_FULL_STATE);
        busy          = !(r_state inside {DECODE_ADDRESS, LOAD_DATA, DROP_DATA, DROP_PARITY});
        write_enb_reg = (r_state inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL});
        rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
        pkt_drop      = (r_state == DROP_DATA) && !r_in_drop;
        w_sel_en      = !(r_state inside {DECODE_ADDRESS, DROP_DATA, DROP_PARITY});
        dest_sel      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            dest_sel[p] = w_sel_en && onehot_bit(4'(r_dest), p);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_np.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_fsm_np
// Brief    : Directed vectors and randomized model comparison for router_fsm_np.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_fsm_np;

    // Output flag order: busy, detect_add, lfd, ld, laf, full, we, rst_int, pkt_drop
    localparam logic [8:0] c_da  = 9'b010000000;
    localparam logic [8:0] c_lfd = 9'b101000000;
    localparam logic [8:0] c_wt  = 9'b100000000;
    localparam logic [8:0] c_ld  = 9'b000100100;
    localparam logic [8:0] c_ff  = 9'b100001000;
    localparam logic [8:0] c_lp  = 9'b100000100;
    localparam logic [8:0] c_laf = 9'b100010100;
    localparam logic [8:0] c_cpe = 9'b100000010;
    localparam logic [8:0] c_dr1 = 9'b000000001;
    localparam logic [8:0] c_drn = 9'b000000000;

    typedef struct packed {
        logic       rst;
        logic       pv;
        logic [1:0] din;
        logic [3:0] empty;
        logic [3:0] full;
        logic [3:0] sr;
        logic       pd;
        logic       lpv;
    } in_t;

    typedef struct {
        int         which;
        in_t        a;
        logic [3:0] sel;
        logic [8:0] flags;
        string      name;
    } vec_t;

    typedef enum int {P_IDLE, P_FIRST, P_WAIT, P_LOAD, P_FULL, P_PAR,
                      P_AFTER, P_CHECK, P_DROP, P_DROP_PAR} phase_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t in4, in3;
    int  n_checks = 0;
    int  n_errors = 0;
    vec_t vecs[$];

    phase_t m_ph[2];
    int     m_dest[2];
    int     m_waited[2];
    bit     m_first[2];

    logic [3:0] sel4;
    logic [2:0] sel3;
    logic busy4, da4, lfd4, ld4, laf4, ff4, we4, ri4, drop4;
    logic busy3, da3, lfd3, ld3, laf3, ff3, we3, ri3, drop3;
    logic [12:0] obs4, obs3;

    assign obs4 = {sel4, busy4, da4, lfd4, ld4, laf4, ff4, we4, ri4, drop4};
    assign obs3 = {1'b0, sel3, busy3, da3, lfd3, ld3, laf3, ff3, we3, ri3, drop3};

    router_fsm_np #(.NUM_PORTS(4), .WAIT_TIMEOUT(0)) dut4 (
        .clock(clk), .reset(in4.rst), .data_in(in4.din), .pkt_valid(in4.pv),
        .parity_done(in4.pd), .low_pkt_valid(in4.lpv), .soft_reset(in4.sr),
        .fifo_full(in4.full), .fifo_empty(in4.empty), .dest_sel(sel4), .busy(busy4),
        .detect_add(da4), .lfd_state(lfd4), .ld_state(ld4), .laf_state(laf4),
        .full_state(ff4), .write_enb_reg(we4), .rst_int_reg(ri4), .pkt_drop(drop4)
    );

    router_fsm_np #(.NUM_PORTS(3), .WAIT_TIMEOUT(5)) dut3 (
        .clock(clk), .reset(in3.rst), .data_in(in3.din), .pkt_valid(in3.pv),
        .parity_done(in3.pd), .low_pkt_valid(in3.lpv), .soft_reset(in3.sr[2:0]),
        .fifo_full(in3.full[2:0]), .fifo_empty(in3.empty[2:0]), .dest_sel(sel3), .busy(busy3),
        .detect_add(da3), .lfd_state(lfd3), .ld_state(ld3), .laf_state(laf3),
        .full_state(ff3), .write_enb_reg(we3), .rst_int_reg(ri3), .pkt_drop(drop3)
    );

    // Reference model: one packet-level step of the router rules.
    function automatic void mstep(input int k, input in_t a);
        int np, tmo, d;
        phase_t nx;
        np  = (k == 0) ? 4 : 3;
        tmo = (k == 0) ? 0 : 5;
        d   = m_dest[k];
        nx  = m_ph[k];
        if (a.rst) begin
            m_ph[k] = P_IDLE; m_dest[k] = 0; m_waited[k] = 0; m_first[k] = 0;
            return;
        end
        if (!(m_ph[k] inside {P_IDLE, P_DROP, P_DROP_PAR}) && a.sr[d]) begin
            nx = P_IDLE;
        end else begin
            case (m_ph[k])
                P_IDLE: if (a.pv) begin
                    m_dest[k] = int'(a.din);
                    if (int'(a.din) >= np)  nx = P_DROP;
                    else if (a.empty[a.din]) nx = P_FIRST;
                    else                     nx = P_WAIT;
                end
                P_FIRST: nx = P_LOAD;
                P_WAIT: begin
                    m_waited[k] = m_waited[k] + 1;
                    if (a.empty[d])                          nx = P_FIRST;
                    else if (tmo > 0 && m_waited[k] >= tmo) nx = P_DROP;
                end
                P_LOAD:     if (a.full[d]) nx = P_FULL; else if (!a.pv) nx = P_PAR;
                P_FULL:     if (!a.full[d]) nx = P_AFTER;
                P_AFTER:    nx = a.pd ? P_IDLE : (a.lpv ? P_PAR : P_LOAD);
                P_PAR:      nx = P_CHECK;
                P_CHECK:    nx = a.full[d] ? P_FULL : P_IDLE;
                P_DROP:     if (!a.pv) nx = P_DROP_PAR;
                P_DROP_PAR: nx = P_IDLE;
                default:    nx = P_IDLE;
            endcase
        end
        m_first[k] = (nx == P_DROP) && (m_ph[k] != P_DROP);
        if (nx != P_WAIT) m_waited[k] = 0;
        m_ph[k] = nx;
    endfunction

    function automatic logic [12:0] mexp(input int k);
        logic [8:0] f;
        logic [3:0] s;
        case (m_ph[k])
            P_IDLE:  f = c_da;
            P_FIRST: f = c_lfd;
            P_WAIT:  f = c_wt;
            P_LOAD:  f = c_ld;
            P_FULL:  f = c_ff;
            P_PAR:   f = c_lp;
            P_AFTER: f = c_laf;
            P_CHECK: f = c_cpe;
            P_DROP:  f = m_first[k] ? c_dr1 : c_drn;
            default: f = c_drn;
        endcase
        s = 4'b0;
        if (!(m_ph[k] inside {P_IDLE, P_DROP, P_DROP_PAR})) s = 4'(1 << m_dest[k]);
        return {s, f};
    endfunction

    function automatic in_t rand_in(input int np);
        in_t a;
        a.rst = ($urandom_range(0, 63) == 0);
        a.pv  = ($urandom_range(0, 3) != 0);
        a.din = 2'($urandom_range(0, 3));
        for (int b = 0; b < 4; b++) begin
            a.empty[b] = ($urandom_range(0, 3) == 0) && (b < np);
            a.full[b]  = ($urandom_range(0, 3) == 0) && (b < np);
        end
        a.sr  = ($urandom_range(0, 31) == 0) ? 4'(1 << $urandom_range(0, np - 1)) : 4'b0;
        a.pd  = ($urandom_range(0, 3) == 0);
        a.lpv = ($urandom_range(0, 3) == 0);
        return a;
    endfunction

    task automatic add(input int w, input logic r, input logic pv, input logic [1:0] din,
                       input logic [3:0] emp, input logic [3:0] full, input logic [3:0] sr,
                       input logic pd, input logic lpv, input logic [3:0] sel,
                       input logic [8:0] fl, input string nm);
        vec_t v;
        v.which = w;
        v.a     = {r, pv, din, emp, full, sr, pd, lpv};
        v.sel   = sel;
        v.flags = fl;
        v.name  = nm;
        vecs.push_back(v);
    endtask

    task automatic tick(input in_t a4, input in_t a3);
        in4 = a4;
        in3 = a3;
        @(posedge clk);
        #1;
        mstep(0, a4);
        mstep(1, a3);
    endtask

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got sel=%b flags=%b, want sel=%b flags=%b",
                     nm, act[12:9], act[8:0], exp[12:9], exp[8:0]);
        end
    endtask

    initial begin
        in_t a;
        in4 = '0;
        in3 = '0;
        a = '0;
        a.rst = 1'b1;
        tick(a, a);
        check("reset_dut4", obs4, {4'b0, c_da});
        check("reset_dut3", obs3, {4'b0, c_da});

        // 4-port: normal packet to port 2
        add(0,0,1,2,4'b0100,0,0,0,0, 4'b0100,c_lfd,"a_lfd");
        add(0,0,1,2,4'b0100,0,0,0,0, 4'b0100,c_ld, "a_ld1");
        add(0,0,1,2,4'b0100,0,0,0,0, 4'b0100,c_ld, "a_ld2");
        add(0,0,0,2,4'b0100,0,0,0,0, 4'b0100,c_lp, "a_lp");
        add(0,0,0,2,4'b0100,0,0,0,0, 4'b0100,c_cpe,"a_cpe");
        add(0,0,0,2,4'b0100,0,0,0,0, 4'b0000,c_da, "a_da");
        // back-pressure, CPE into full, soft reset on other/selected port
        add(0,0,1,2,4'b0100,0,0,0,0,       4'b0100,c_lfd,"b_lfd");
        add(0,0,1,2,4'b0100,0,0,0,0,       4'b0100,c_ld, "b_ld");
        add(0,0,1,2,0,4'b0100,0,0,0,       4'b0100,c_ff, "b_ff1");
        add(0,0,1,2,0,4'b0100,0,0,0,       4'b0100,c_ff, "b_ff2");
        add(0,0,1,2,0,0,0,0,0,             4'b0100,c_laf,"b_laf");
        add(0,0,1,2,0,0,0,0,0,             4'b0100,c_ld, "b_ld_again");
        add(0,0,0,2,0,0,0,0,0,             4'b0100,c_lp, "b_lp");
        add(0,0,0,2,0,4'b0100,0,0,0,       4'b0100,c_cpe,"b_cpe");
        add(0,0,0,2,0,4'b0100,0,0,0,       4'b0100,c_ff, "b_cpe_to_ff");
        add(0,0,0,2,0,4'b0100,4'b0001,0,0, 4'b0100,c_ff, "b_sr_other");
        add(0,0,0,2,0,4'b0100,4'b0100,0,0, 4'b0000,c_da, "b_sr_sel");
        // LAF exits via low_pkt_valid, then parity_done priority
        add(0,0,1,0,4'b0001,0,0,0,0,       4'b0001,c_lfd,"c_lfd");
        add(0,0,1,0,0,0,0,0,0,             4'b0001,c_ld, "c_ld");
        add(0,0,1,0,0,4'b0001,0,0,0,       4'b0001,c_ff, "c_ff");
        add(0,0,1,0,0,0,0,0,0,             4'b0001,c_laf,"c_laf");
        add(0,0,0,0,0,0,0,0,1,             4'b0001,c_lp, "c_lpv_to_lp");
        add(0,0,0,0,0,0,0,0,0,             4'b0001,c_cpe,"c_cpe");
        add(0,0,0,0,0,0,0,0,0,             4'b0000,c_da, "c_da");
        add(0,0,1,3,4'b1000,0,0,0,0,       4'b1000,c_lfd,"d_lfd");
        add(0,0,1,3,0,0,0,0,0,             4'b1000,c_ld, "d_ld");
        add(0,0,1,3,0,4'b1000,0,0,0,       4'b1000,c_ff, "d_ff");
        add(0,0,1,3,0,0,0,0,0,             4'b1000,c_laf,"d_laf");
        add(0,0,0,3,0,0,0,1,1,             4'b0000,c_da, "d_pd_wins");
        // wait without timeout, then reset beating soft reset mid LOAD_DATA
        add(0,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "e_wt");
        add(0,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "e_wt2");
        add(0,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "e_wt3");
        add(0,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "e_wt4");
        add(0,0,1,1,4'b0010,0,0,0,0,       4'b0010,c_lfd,"e_lfd");
        add(0,0,1,1,0,0,0,0,0,             4'b0010,c_ld, "e_ld");
        add(0,1,1,1,0,0,4'b0010,0,0,       4'b0000,c_da, "e_reset");
        add(0,0,1,2,4'b0100,0,0,0,0,       4'b0100,c_lfd,"f_lfd");
        add(0,0,1,2,0,0,4'b0100,0,0,       4'b0000,c_da, "f_sr_in_lfd");
        add(0,0,1,2,4'b0100,0,4'b0100,0,0, 4'b0100,c_lfd,"f_sr_ignored_da");
        add(0,0,0,2,0,0,0,0,0,             4'b0100,c_ld, "f_ld");
        add(0,0,0,2,0,0,0,0,0,             4'b0100,c_lp, "f_lp");
        add(0,0,0,2,0,0,0,0,0,             4'b0100,c_cpe,"f_cpe");
        add(0,0,0,2,0,0,0,0,0,             4'b0000,c_da, "f_da");
        // 3-port: out-of-range drop, soft reset ignored while dropping
        add(1,0,1,3,0,0,0,0,0,             4'b0000,c_dr1,"g_drop_first");
        add(1,0,1,3,0,0,0,0,0,             4'b0000,c_drn,"g_drop2");
        add(1,0,1,3,0,4'b0111,4'b0111,0,0, 4'b0000,c_drn,"g_drop_sr");
        add(1,0,1,3,0,0,0,0,0,             4'b0000,c_drn,"g_drop4");
        add(1,0,0,3,0,0,0,0,0,             4'b0000,c_drn,"g_drop_par");
        add(1,0,0,3,0,0,0,0,0,             4'b0000,c_da, "g_da");
        // 3-port: timeout after five wait cycles
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "h_wt1");
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "h_wt2");
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "h_wt3");
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "h_wt4");
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "h_wt5");
        add(1,0,1,1,0,0,0,0,0,             4'b0000,c_dr1,"h_timeout_drop");
        add(1,0,0,1,0,0,0,0,0,             4'b0000,c_drn,"h_drop_par");
        add(1,0,0,1,0,0,0,0,0,             4'b0000,c_da, "h_da");
        // 3-port: empty arriving on the last allowed cycle wins
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "i_wt1");
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "i_wt2");
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "i_wt3");
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "i_wt4");
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_wt, "i_wt5");
        add(1,0,1,1,4'b0010,0,0,0,0,       4'b0010,c_lfd,"i_empty_wins");
        add(1,0,1,1,0,0,0,0,0,             4'b0010,c_ld, "i_ld");
        add(1,0,0,1,0,0,0,0,0,             4'b0010,c_lp, "i_lp");
        add(1,0,0,1,0,0,0,0,0,             4'b0010,c_cpe,"i_cpe");
        add(1,0,0,1,0,0,0,0,0,             4'b0000,c_da, "i_da");

        foreach (vecs[i]) begin
            if (vecs[i].which == 0) tick(vecs[i].a, '0);
            else                    tick('0, vecs[i].a);
            check(vecs[i].name, (vecs[i].which == 0) ? obs4 : obs3, {vecs[i].sel, vecs[i].flags});
        end

        for (int c = 0; c < 3000; c++) begin
            in_t r4, r3;
            r4 = rand_in(4);
            r3 = rand_in(3);
            tick(r4, r3);
            check("rand_dut4", obs4, mexp(0));
            check("rand_dut3", obs3, mexp(1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
Parametrised successor to the 1x3 router control FSM. It steers one input packet stream to one of NUM_PORTS output FIFOs. It latches the destination address from the header, sequences header, payload and parity loads, and handles full-FIFO back-pressure. New over the 3-port FSM: per-port full/empty/soft-reset vectors indexed internally, out-of-range address drop, and a bounded wait-till-empty timeout.

Parameters:
NUM_PORTS, 3, number of destination FIFOs (2..16)
ADDR_W, $clog2(NUM_PORTS) (min 1), header address field width
WAIT_TIMEOUT, 0, cycles allowed in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout
TMR_W, 8, width of the wait timer; WAIT_TIMEOUT < 2**TMR_W

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
data_in  in  ADDR_W  header address bits, sampled in DECODE_ADDRESS
pkt_valid  in  1  high during header and payload; low on the parity byte
parity_done  in  1  parity byte has been written
low_pkt_valid  in  1  pkt_valid fell while the FSM was stalled
soft_reset  in  NUM_PORTS  per-port read-timeout soft reset
fifo_full  in  NUM_PORTS  per-port FIFO full
fifo_empty  in  NUM_PORTS  per-port FIFO empty
dest_sel  out  NUM_PORTS  one-hot latched destination; 0 in DECODE_ADDRESS and drop states
busy  out  1  stall the source
detect_add, lfd_state, ld_state, laf_state, full_state  out  1  state strobes
write_enb_reg  out  1  write enable to the register/FIFO path
rst_int_reg  out  1  clear internal parity registers
pkt_drop  out  1  one-cycle pulse on entering DROP_DATA

Behaviour:
- State register: 4 bits. States: DECODE_ADDRESS=0, LOAD_FIRST_DATA=1, WAIT_TILL_EMPTY=2, LOAD_DATA=3, FIFO_FULL_STATE=4, LOAD_PARITY=5, LOAD_AFTER_FULL=6, CHECK_PARITY_ERROR=7, DROP_DATA=8, DROP_PARITY=9. Codes 10-15 return to DECODE_ADDRESS.
- reset=1 at a clock edge: state=DECODE_ADDRESS, dest_q=0, timer=0. Outputs then read detect_add=1 and every other output 0. reset overrides everything.
- Outputs are combinational from state; dest_q selects the port.
- Priority: reset > soft_reset[dest_q] (in any state except DECODE_ADDRESS/DROP_*, go to DECODE_ADDRESS next edge) > normal transitions.
- DECODE_ADDRESS:
  - If pkt_valid and data_in >= NUM_PORTS: go to DROP_DATA.
  - If pkt_valid and fifo_empty[data_in]: go to LOAD_FIRST_DATA.
  - If pkt_valid and not fifo_empty[data_in]: go to WAIT_TILL_EMPTY.
  - dest_q <= data_in whenever pkt_valid is high.
- LOAD_FIRST_DATA: go to LOAD_DATA unconditionally.
- WAIT_TILL_EMPTY:
  - timer increments every cycle in this state and clears on exit.
  - If fifo_empty[dest_q]: go to LOAD_FIRST_DATA.
  - Else if WAIT_TIMEOUT != 0 and timer == WAIT_TIMEOUT-1: go to DROP_DATA.
  - Empty has priority over timeout in the same cycle.
- LOAD_DATA: if fifo_full[dest_q], go to FIFO_FULL_STATE; else if !pkt_valid, go to LOAD_PARITY; else stay.
- FIFO_FULL_STATE: go to LOAD_AFTER_FULL when !fifo_full[dest_q].
- LOAD_AFTER_FULL: if parity_done, go to DECODE_ADDRESS; else if low_pkt_valid, go to LOAD_PARITY; else go to LOAD_DATA.
- LOAD_PARITY: go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: if fifo_full[dest_q], go to FIFO_FULL_STATE; else go to DECODE_ADDRESS.
- DROP_DATA: stay while pkt_valid; on !pkt_valid go to DROP_PARITY. That cycle consumes the parity byte.
- DROP_PARITY: go to DECODE_ADDRESS.
- Output decode:
  - busy=1 in every state except DECODE_ADDRESS, LOAD_DATA, DROP_DATA, DROP_PARITY. Drop states never stall the source.
  - write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
  - rst_int_reg=1 in CHECK_PARITY_ERROR.
  - Each strobe is 1 only in its namesake state.
  - pkt_drop=1 on the first cycle of DROP_DATA only.
  - dest_sel = 1<<dest_q outside DECODE_ADDRESS/DROP_*.
- Vector inputs are only ever indexed with an in-range dest_q; out-of-range bits are never read.

Decomposition:
- Package router_pkg: state enum/localparams, ADDR_W function, one-hot helper.
- Optional sub-module router_wait_timer: counter with clear/enable/expire. Everything else lives in one FSM module.

Test Plan:
- NUM_PORTS=4, data_in=2, fifo_empty=4'b0100, pkt_valid high 3 cycles then low -> states 0,1,3,3,5,7,0; dest_sel=4'b0100 from LOAD_FIRST_DATA through CHECK_PARITY_ERROR; write_enb_reg high in LOAD_DATA and LOAD_PARITY.
- In LOAD_DATA, fifo_full[2]=1 for 2 cycles, then 0 with low_pkt_valid=0 -> 3,4,4,6,3; busy=1 in states 4 and 6; laf_state pulses once.
- NUM_PORTS=3, data_in=3, pkt_valid high 4 cycles -> pkt_drop one cycle, busy=0 throughout, states 8,8,8,8,9,0; write_enb_reg never asserted.
- WAIT_TIMEOUT=5, fifo_empty[1]=0 held -> 5 cycles in WAIT_TILL_EMPTY then DROP_DATA. Repeat with fifo_empty[1] rising on cycle 5 -> LOAD_FIRST_DATA, no drop.
- soft_reset[dest_q] in FIFO_FULL_STATE -> DECODE_ADDRESS next edge. soft_reset on a non-selected port -> no effect.
- reset asserted mid LOAD_DATA -> next edge state 0, detect_add=1, busy=0, dest_sel=0. With reset and soft_reset both high, reset wins.
